// File: rtl/push_btn_scanner_pkg.sv
// Shared pushbutton definitions: controller opcodes, peripheral opcodes and
// scanner state encodings.
package push_btn_scanner_pkg;

   localparam int InstW = 12;

   typedef enum logic [3:0] {
      OP_NOP  = 4'h0,
      OP_ENAB = 4'h1,
      OP_DISB = 4'h2,
      OP_RDMK = 4'h3
   } ctl_op_e;

   // Opcodes understood by the pushbutton peripherals on btn_inst[11:8].
   localparam logic [3:0] BTN_NOP  = 4'h0;
   localparam logic [3:0] BTN_RDBS = 4'h1;

   typedef enum logic [2:0] {
      S_RESET,
      S_IDLE,
      S_WAIT,
      S_ISSUE,
      S_CAPTURE,
      S_ERROR
   } scan_state_e;

   function automatic logic op_legal(input logic [3:0] op);
      return op <= OP_RDMK;
   endfunction

endpackage

// File: rtl/push_btn_scanner_scan_timer.sv
// Down-counting period timer: load has priority over enable, holds at zero.
module scan_timer #(
   parameter int PeriodSize = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  load,
   input  logic [PeriodSize-1:0] load_val,
   input  logic                  enable,
   output logic                  zero
);

   logic [PeriodSize-1:0] count;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (enable && (count != '0)) begin
         count <= count - PeriodSize'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/push_btn_scanner.sv
// Periodically polls NumBtns pushbutton peripherals with RDBS and accumulates
// their pressed status into a mask the controller reads back with RDMK.
module push_btn_scanner
   import push_btn_scanner_pkg::*;
#(
   parameter int NumBtns    = 4,
   parameter int ScanPeriod = 1000,
   parameter int PeriodSize = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [InstW-1:0]   inst,
   input  logic               inst_en,
   output logic [InstW-1:0]   btn_inst,
   output logic [NumBtns-1:0] btn_inst_en,
   input  logic [NumBtns-1:0] btn_status,
   output logic [NumBtns-1:0] mask,
   output logic               pending
);

   localparam int IdxW = (NumBtns > 1) ? $clog2(NumBtns) : 1;
   localparam logic [IdxW-1:0]       LastIdx    = IdxW'(NumBtns - 1);
   localparam logic [PeriodSize-1:0] PeriodLoad = PeriodSize'(ScanPeriod - 1);

   scan_state_e          state;
   logic [IdxW-1:0]      idx;
   logic [NumBtns-1:0]   acc;
   logic                 drain;
   logic                 zero;

   logic [3:0]           opc;
   logic                 enab, disb, rdmk, illegal;
   logic                 tmr_load, tmr_en;
   logic [NumBtns-1:0]   cap_bits;
   logic [IdxW-1:0]      idx_next;
   logic                 unused_inst_bits;

   assign opc     = inst[11:8];
   assign enab    = inst_en && (opc == OP_ENAB);
   assign disb    = inst_en && (opc == OP_DISB);
   assign rdmk    = inst_en && (opc == OP_RDMK);
   assign illegal = inst_en && !op_legal(opc);
   assign unused_inst_bits = ^inst[7:0];

   assign idx_next = idx + IdxW'(1);

   // drain covers an RDBS that was already on the bus when DISB arrived.
   assign cap_bits = ((state == S_CAPTURE) || drain) ?
                     (btn_status & (NumBtns'(1) << idx)) : '0;

   assign tmr_load = ((state == S_IDLE) && enab) ||
                     ((state == S_CAPTURE) && (idx == LastIdx) && !disb && !illegal);
   assign tmr_en   = (state == S_WAIT) && !zero;

   scan_timer #(.PeriodSize(PeriodSize)) u_timer (
      .clock    (clock),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (PeriodLoad),
      .enable   (tmr_en),
      .zero     (zero)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= S_RESET;
         idx         <= '0;
         acc         <= '0;
         mask        <= '0;
         drain       <= 1'b0;
         btn_inst    <= '0;
         btn_inst_en <= '0;
      end else begin
         btn_inst    <= '0;
         btn_inst_en <= '0;
         drain       <= 1'b0;
         if (state != S_ERROR) begin
            if (illegal) begin
               state <= S_ERROR;
               acc   <= '0;
               mask  <= '0;
            end else begin
               if (rdmk) begin
                  mask <= acc;
                  acc  <= cap_bits;
               end else begin
                  acc  <= acc | cap_bits;
               end
               case (state)
                  S_RESET: state <= S_IDLE;
                  S_IDLE: begin
                     if (enab) state <= S_WAIT;
                  end
                  S_WAIT: begin
                     if (disb) begin
                        state <= S_IDLE;
                     end else if (zero) begin
                        state       <= S_ISSUE;
                        idx         <= '0;
                        btn_inst    <= {BTN_RDBS, 8'h00};
                        btn_inst_en <= NumBtns'(1);
                     end
                  end
                  S_ISSUE: begin
                     if (disb) begin
                        state <= S_IDLE;
                        drain <= 1'b1;
                     end else begin
                        state <= S_CAPTURE;
                     end
                  end
                  S_CAPTURE: begin
                     if (disb) begin
                        state <= S_IDLE;
                     end else if (idx == LastIdx) begin
                        state <= S_WAIT;
                     end else begin
                        state       <= S_ISSUE;
                        idx         <= idx_next;
                        btn_inst    <= {BTN_RDBS, 8'h00};
                        btn_inst_en <= NumBtns'(1) << idx_next;
                     end
                  end
                  default: state <= S_ERROR;
               endcase
            end
         end
      end
   end

   assign pending = |acc;

endmodule
